// File: rtl/tristate_bus_arbiter.sv
// Purpose : round-robin arbiter that hands one requester at a time the shared
//           tristate bus, with a fixed idle turnaround between owners.
// Latency : grant/bus drive one edge after req is seen in IDLE; rdata/rvalid one edge after a DRIVE cycle.
// Backpressure: none; an owner holds the bus until its req drops (or, with HOLD_LIMIT_EN, MAX_HOLD cycles).
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   req[NREQ]       level-sensitive per-requester bus request
//   wdata[NREQ*W]   per-requester drive data, slice i = wdata[i*WIDTH +: WIDTH]
//   bus[W]          shared tristate bus, driven only in DRIVE with the owner's slice
//   grant[NREQ]     one-hot owner indication (zero when nobody drives)
//   busy            high in DRIVE and TURN
//   rdata/rvalid    registered bus sample and its qualifier
// Build option: define HOLD_LIMIT_EN to preempt an owner after MAX_HOLD DRIVE cycles.
module tristate_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int TURN     = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  inout  wire  [WIDTH-1:0]      bus,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid
);

  localparam int IDXW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TURN < 1 || TURN > 15 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
    $error("tristate_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  // last_q doubles as the current owner while in DRIVE.
  logic [IDXW-1:0]   last_q, last_d;
  logic [3:0]        tcnt_q, tcnt_d;
  logic              rvalid_q;
  logic [WIDTH-1:0]  rdata_q;
  logic              hold_exp;

  logic [WIDTH-1:0]  wslice [NREQ];
  logic [IDXW-1:0]   pick;
  logic [IDXW-1:0]   cand;
  logic              found;
  int                rr_idx;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign wslice[g] = wdata[g*WIDTH +: WIDTH];
  end

  // Round-robin search starting one past the previous owner.
  always_comb begin
    pick   = last_q;
    cand   = '0;
    found  = 1'b0;
    rr_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = (int'(last_q) + k) % NREQ;
      cand   = IDXW'(rr_idx);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

`ifdef HOLD_LIMIT_EN
  logic [7:0] hold_q, hold_d;

  // hold_q numbers the current DRIVE cycle (1-based); the MAX_HOLD-th one is the last.
  assign hold_exp = (hold_q == 8'(MAX_HOLD));

  always_comb begin
    hold_d = 8'd0;
    if (state_d == S_DRIVE) begin
      hold_d = (state_q == S_DRIVE) ? hold_q + 8'd1 : 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= 8'd0;
    else        hold_q <= hold_d;
  end
`else
  assign hold_exp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_DRIVE;
          last_d  = pick;
        end
      end
      S_DRIVE: begin
        // Release and hold expiry on the same edge collapse into one TURN.
        if (!req[last_q] || hold_exp) begin
          state_d = S_TURN;
          tcnt_d  = 4'd0;
        end
      end
      S_TURN: begin
        if (tcnt_q == 4'(TURN - 1)) begin
          if (found) begin
            state_d = S_DRIVE;
            last_d  = pick;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tcnt_d = tcnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      last_q   <= IDXW'(NREQ - 1);
      tcnt_q   <= 4'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      tcnt_q   <= tcnt_d;
      rvalid_q <= (state_q == S_DRIVE);
      if (state_q == S_DRIVE) rdata_q <= bus;
    end
  end

  // Everything visible is decoded from registered state only; reset clears
  // state_q asynchronously, which releases the bus without a clock.
  always_comb begin
    grant = '0;
    if (state_q == S_DRIVE) grant[last_q] = 1'b1;
  end

  assign busy   = (state_q != S_IDLE);
  assign bus    = (state_q == S_DRIVE) ? wslice[last_q] : {WIDTH{1'bz}};
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: doc/tristate_bus_arbiter.md
TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the bus, range 2..8.
REQ-002 Parameter WIDTH, default 8: shared bus width in bits.
REQ-003 Parameter TURN, default 1: idle turnaround cycles between owners, range 1..15.
REQ-004 Parameter MAX_HOLD, default 8: maximum consecutive DRIVE cycles per grant, range 1..255; used only with HOLD_LIMIT_EN.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req  input  NREQ  per-requester bus request, level-sensitive.
REQ-008 wdata  input  NREQ*WIDTH  per-requester drive data; slice i is bits [i*WIDTH +: WIDTH].
REQ-009 bus  inout  WIDTH  shared tristate bus; carries wdata of owner, otherwise all z.
REQ-010 grant  output  NREQ  one-hot owner indication; all zero when no owner.
REQ-011 busy  output  1  high in DRIVE and TURN states.
REQ-012 rdata  output  WIDTH  registered sample of bus.
REQ-013 rvalid  output  1  high the cycle after a DRIVE cycle; qualifies rdata.

Function
REQ-014 FSM states: IDLE, DRIVE, TURN; encoding is implementation choice.
REQ-015 Bus SHALL be driven only when state is DRIVE: bus = wdata slice of owner, else all bits z.
REQ-016 grant, busy, and the bus enable SHALL derive only from registered state; no combinational path from req to bus or grant.
REQ-017 IDLE: any req bit set -> select owner by round-robin; DRIVE and grant asserted from the next edge (1-cycle latency).
REQ-018 Round-robin: search starts at last_owner+1 modulo NREQ; first set req bit wins; last_owner updates on each grant.
REQ-019 DRIVE: stays while req[owner] is high; req[owner] low at an edge -> TURN, grant cleared, bus z from that edge.
REQ-020 Changes on req bits other than owner's SHALL NOT affect DRIVE.
REQ-021 TURN: exactly TURN cycles with no driver; on expiry, any req set -> DRIVE with new round-robin owner, else -> IDLE.
REQ-022 Back-to-back grant gap: bus z for exactly TURN cycles between owners, never 0.
REQ-023 rdata/rvalid: each edge, rvalid <= (state==DRIVE), rdata <= bus when state==DRIVE, else rdata holds.
REQ-024 Owner whose req drops in the same cycle it would be granted: grant still issued; it releases on the following edge (1 DRIVE cycle).

Reset
REQ-025 rst_n low: state IDLE, grant 0, busy 0, rvalid 0, rdata 0, last_owner NREQ-1 (req[0] wins first arbitration), hold counter 0.
REQ-026 Reset mid-DRIVE SHALL release bus to z immediately, without waiting for clk.
REQ-027 First arbitration occurs on the first rising edge with rst_n high.

Configuration
REQ-028 Macro HOLD_LIMIT_EN defined: hold counter counts DRIVE cycles; at the MAX_HOLD-th cycle, force DRIVE -> TURN even if req[owner] still high.
REQ-029 With HOLD_LIMIT_EN, a preempted requester still requesting is re-arbitrated normally after TURN; if it is the sole requester, it is re-granted.
REQ-030 With HOLD_LIMIT_EN, req drop and hold expiry on the same edge produce a single TURN.
REQ-031 Macro HOLD_LIMIT_EN undefined: no hold counter; ownership lasts until req[owner] drops.

Verification
REQ-032 Reset, then req=0001, wdata0=8'hA5 -> grant=0001 next edge; bus=A5; rvalid=1, rdata=A5 one cycle later.
REQ-033 req=0101 held (no HOLD_LIMIT_EN); drop req0 after 3 DRIVE cycles -> 1 z cycle (TURN=1), then grant=0100, bus=wdata2.
REQ-034 All req=1111 with each owner dropping after 2 cycles -> grant order 0001,0010,0100,1000,0001; never two grant bits set.
REQ-035 rst_n low mid-DRIVE between edges -> bus z and grant=0 immediately; rvalid=0.
REQ-036 HOLD_LIMIT_EN, MAX_HOLD=4, req=0011 held -> owner0 for 4 cycles, TURN, owner1 for 4 cycles, TURN, owner0 again.
REQ-037 Contention check on every bench: bus never has two drivers; bus never x while grant nonzero.
